common_madd_fixed: RTL and testbench

COMMON_MADD_FIXED -- requirements
Module: common_madd_fixed

---
 rtl/common_madd_fixed_pkg.sv | 27 ++
 rtl/artec_vr_if.sv | 11 +
 rtl/fixed_round_sat.sv | 45 ++++
 rtl/common_madd_fixed.sv | 151 +++++++++++++++
 tb/tb_common_madd_fixed.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/common_madd_fixed_pkg.sv
// Shared constants and width helpers for the fixed-point multiply-add pipeline.
package common_madd_fixed_pkg;

    localparam int LATENCY = 4;

    function automatic int max_i(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Each operand carries one extension bit so signed and unsigned share one multiplier.
    function automatic int prod_w(input int aw, input int bw);
        return aw + bw + 2;
    endfunction

    function automatic int c_aligned_w(input int cw, input int cpoint, input int p);
        return (p >= cpoint) ? cw + 1 + (p - cpoint) : cw + 1;
    endfunction

    function automatic int sum_w(input int pw, input int caw);
        return max_i(pw, caw) + 1;
    endfunction

    function automatic int rescale_w(input int iw, input int shift);
        return (shift < 0) ? iw + 1 - shift : iw + 1;
    endfunction

endpackage

// File: rtl/artec_vr_if.sv
// Valid/ready stream bundle used to wrap block ports in benches.
interface artec_vr_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fixed_round_sat.sv
// Rescales a signed fixed-point sum to the output point, optionally rounds half-up, then saturates.
module fixed_round_sat
    import common_madd_fixed_pkg::*;
#(
    parameter int IN_W       = 66,
    parameter int SHIFT      = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int OUT_SIGNED = 0,
    parameter int ROUND      = 0
) (
    input  logic signed [IN_W-1:0]      din,
    output logic        [OUT_WIDTH-1:0] dout
);

    localparam int CW  = max_i(rescale_w(IN_W, SHIFT), OUT_WIDTH + 2);
    localparam int RSH = (SHIFT > 0) ? SHIFT : 0;
    localparam int LSH = (SHIFT < 0) ? -SHIFT : 0;
    localparam logic signed [CW-1:0] HALF =
        (ROUND != 0 && RSH > 0) ? (CW'(1) <<< ((RSH > 0) ? RSH - 1 : 0)) : '0;

    function automatic logic signed [CW-1:0] rescale(input logic signed [IN_W-1:0] x);
        logic signed [CW-1:0] w;
        w = CW'(x);
        w = (w + HALF) >>> RSH;
        return w <<< LSH;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [CW-1:0] x);
        logic signed [CW-1:0] hi;
        logic signed [CW-1:0] lo;
        if (OUT_SIGNED != 0) begin
            hi = (CW'(1) <<< (OUT_WIDTH - 1)) - CW'(1);
            lo = -(CW'(1) <<< (OUT_WIDTH - 1));
        end else begin
            hi = (CW'(1) <<< OUT_WIDTH) - CW'(1);
            lo = '0;
        end
        if (x > hi) return hi[OUT_WIDTH-1:0];
        if (x < lo) return lo[OUT_WIDTH-1:0];
        return x[OUT_WIDTH-1:0];
    endfunction

    assign dout = saturate(rescale(din));

endmodule

// File: rtl/common_madd_fixed.sv
// Four-stage fixed-point out = a*b + c with valid/ready handshake and a global stall.
module common_madd_fixed
    import common_madd_fixed_pkg::*;
#(
    parameter int U_WIDTH    = 16,
    parameter int A_WIDTH    = 32,
    parameter int A_POINT    = 16,
    parameter int A_SIGNED   = 0,
    parameter int B_WIDTH    = 32,
    parameter int B_POINT    = 16,
    parameter int B_SIGNED   = 0,
    parameter int C_WIDTH    = 32,
    parameter int C_POINT    = 16,
    parameter int C_SIGNED   = 0,
    parameter int OUT_WIDTH  = 32,
    parameter int OUT_POINT  = 16,
    parameter int OUT_SIGNED = 0,
    parameter int ROUND      = 0,
    parameter int XILINX     = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [A_WIDTH-1:0]   a_i,
    input  logic [B_WIDTH-1:0]   b_i,
    input  logic [C_WIDTH-1:0]   c_i,
    input  logic [U_WIDTH-1:0]   user_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [OUT_WIDTH-1:0] out_o,
    output logic [U_WIDTH-1:0]   user_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam int P     = A_POINT + B_POINT;
    localparam int PW    = prod_w(A_WIDTH, B_WIDTH);
    localparam int CAW   = c_aligned_w(C_WIDTH, C_POINT, P);
    localparam int SW    = sum_w(PW, CAW);
    localparam int CSH_L = (P >= C_POINT) ? P - C_POINT : 0;
    localparam int CSH_R = (P >= C_POINT) ? 0 : C_POINT - P;

    logic advance;
    logic vld_p0, vld_p1, vld_p2, vld_p3;

    logic [A_WIDTH-1:0]   a_p0;
    logic [B_WIDTH-1:0]   b_p0;
    logic [C_WIDTH-1:0]   c_p0;
    logic [U_WIDTH-1:0]   user_p0, user_p1, user_p2, user_p3;
    logic signed [A_WIDTH:0] a_ext;
    logic signed [B_WIDTH:0] b_ext;
    logic signed [PW-1:0] prod_p1;
    logic signed [CAW-1:0] c_al;
    logic signed [SW-1:0] sum_p2;
    logic [OUT_WIDTH-1:0] out_nx, out_p3;

    function automatic logic signed [CAW-1:0] align_c(input logic [C_WIDTH-1:0] c);
        logic signed [C_WIDTH:0] e;
        logic signed [CAW-1:0]   w;
        e = (C_SIGNED != 0) ? {c[C_WIDTH-1], c} : {1'b0, c};
        w = CAW'(e);
        return (w <<< CSH_L) >>> CSH_R;
    endfunction

    // A full pipeline only moves when the consumer takes the head result.
    assign advance = ready_i || !vld_p3;
    assign ready_o = advance && !rstn;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (advance) begin
            vld_p0 <= valid_i;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    // p0: input register
    always_ff @(posedge clk) begin
        if (advance) begin
            a_p0    <= a_i;
            b_p0    <= b_i;
            c_p0    <= c_i;
            user_p0 <= user_i;
        end
    end

    assign a_ext = (A_SIGNED != 0) ? {a_p0[A_WIDTH-1], a_p0} : {1'b0, a_p0};
    assign b_ext = (B_SIGNED != 0) ? {b_p0[B_WIDTH-1], b_p0} : {1'b0, b_p0};

    // p1: multiply
    always_ff @(posedge clk) begin
        if (advance) begin
            prod_p1 <= PW'(a_ext) * PW'(b_ext);
            user_p1 <= user_p0;
        end
    end

    // DSP mode registers the pre-aligned addend like a C-port register; generic aligns at the adder.
    generate
        if (XILINX != 0) begin : g_dsp
            logic signed [CAW-1:0] c_al_p1;
            always_ff @(posedge clk) begin
                if (advance) c_al_p1 <= align_c(c_p0);
            end
            assign c_al = c_al_p1;
        end else begin : g_rtl
            logic [C_WIDTH-1:0] c_p1;
            always_ff @(posedge clk) begin
                if (advance) c_p1 <= c_p0;
            end
            assign c_al = align_c(c_p1);
        end
    endgenerate

    // p2: add
    always_ff @(posedge clk) begin
        if (advance) begin
            sum_p2  <= SW'(prod_p1) + SW'(c_al);
            user_p2 <= user_p1;
        end
    end

    fixed_round_sat #(
        .IN_W      (SW),
        .SHIFT     (P - OUT_POINT),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_SIGNED(OUT_SIGNED),
        .ROUND     (ROUND)
    ) u_round_sat (
        .din (sum_p2),
        .dout(out_nx)
    );

    // p3: round/saturate
    always_ff @(posedge clk) begin
        if (advance) begin
            out_p3  <= out_nx;
            user_p3 <= user_p2;
        end
    end

    assign out_o   = out_p3;
    assign user_o  = user_p3;
    assign valid_o = vld_p3;

endmodule

// File: tb/tb_common_madd_fixed.sv
// Bench for common_madd_fixed: three parameterisations share one stream, checked against an arithmetic model.
module tb_common_madd_fixed;
    import common_madd_fixed_pkg::*;

    localparam int W = 32;
    localparam int U = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    artec_vr_if #(.DW(3*W)) in_if ();
    artec_vr_if #(.DW(W))   out_if ();

    logic [U-1:0] user_in, user_def, user_rnd, user_sgn;
    logic [W-1:0] out_rnd, out_sgn;
    logic         vo_rnd, vo_sgn, ro_rnd, ro_sgn;

    common_madd_fixed u_def (
        .clk(clk), .rstn(rst),
        .a_i(in_if.data[3*W-1:2*W]), .b_i(in_if.data[2*W-1:W]), .c_i(in_if.data[W-1:0]),
        .user_i(user_in), .valid_i(in_if.valid), .ready_o(in_if.ready),
        .out_o(out_if.data), .user_o(user_def), .valid_o(out_if.valid), .ready_i(out_if.ready)
    );

    common_madd_fixed #(.ROUND(1), .XILINX(0)) u_rnd (
        .clk(clk), .rstn(rst),
        .a_i(in_if.data[3*W-1:2*W]), .b_i(in_if.data[2*W-1:W]), .c_i(in_if.data[W-1:0]),
        .user_i(user_in), .valid_i(in_if.valid), .ready_o(ro_rnd),
        .out_o(out_rnd), .user_o(user_rnd), .valid_o(vo_rnd), .ready_i(out_if.ready)
    );

    common_madd_fixed #(.A_SIGNED(1), .B_SIGNED(1), .C_SIGNED(1), .OUT_SIGNED(1)) u_sgn (
        .clk(clk), .rstn(rst),
        .a_i(in_if.data[3*W-1:2*W]), .b_i(in_if.data[2*W-1:W]), .c_i(in_if.data[W-1:0]),
        .user_i(user_in), .valid_i(in_if.valid), .ready_o(ro_sgn),
        .out_o(out_sgn), .user_o(user_sgn), .valid_o(vo_sgn), .ready_i(out_if.ready)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic [W-1:0] r;
        logic [W-1:0] s;
        logic [U-1:0] u;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Real-valued meaning: a, b, c each carry 16 fractional bits; result floor-scaled back to 16.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input bit sgn, input bit rnd);
        logic signed [127:0] ea, eb, ec, v, hi, lo;
        ea = sgn ? {{96{a[W-1]}}, a} : {96'd0, a};
        eb = sgn ? {{96{b[W-1]}}, b} : {96'd0, b};
        ec = sgn ? {{96{c[W-1]}}, c} : {96'd0, c};
        v  = ea * eb + ec * 65536;
        if (rnd) v = v + 32768;
        v  = v >>> 16;
        hi = sgn ? 128'sd2147483647 : 128'sd4294967295;
        lo = sgn ? -128'sd2147483648 : 128'sd0;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 2))
            0:       return W'($urandom_range(0, 'h3FFFF));
            1:       return W'($urandom);
            default: return 32'hFFFF_FFFF - W'($urandom_range(0, 'h3FFFF));
        endcase
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [U-1:0] u, input logic v);
        in_if.data  = {a, b, c};
        user_in     = u;
        in_if.valid = v;
    endtask

    // One clock: check the head result before the edge, update the scoreboard after it.
    task automatic tick();
        bit   acc, xfer;
        exp_t e, n;
        logic [W-1:0] a, b, c;
        #2;
        acc  = in_if.valid && in_if.ready;
        xfer = out_if.valid && out_if.ready;
        check("ready_def", in_if.ready, out_if.ready || !out_if.valid);
        check("ready_rnd", ro_rnd, out_if.ready || !out_if.valid);
        check("ready_sgn", ro_sgn, out_if.ready || !out_if.valid);
        if (out_if.valid) begin
            if (q.size() == 0) begin
                check("extra_output", out_if.valid, 1'b0);
            end else begin
                e = q[0];
                check("out_def", out_if.data, e.d);
                check("out_rnd", out_rnd, e.r);
                check("out_sgn", out_sgn, e.s);
                check("user_def", user_def, e.u);
                check("user_rnd", user_rnd, e.u);
                check("user_sgn", user_sgn, e.u);
                check("valid_rnd", vo_rnd, 1'b1);
                check("valid_sgn", vo_sgn, 1'b1);
            end
        end
        a = in_if.data[3*W-1:2*W];
        b = in_if.data[2*W-1:W];
        c = in_if.data[W-1:0];
        n.d = model(a, b, c, 1'b0, 1'b0);
        n.r = model(a, b, c, 1'b0, 1'b1);
        n.s = model(a, b, c, 1'b1, 1'b0);
        n.u = user_in;
        @(posedge clk);
        #1;
        if (xfer && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(n);
    endtask

    // Single transaction; returns with its result on the outputs (acceptance edge is cycle 1).
    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                            input logic [U-1:0] u);
        drive(a, b, c, u, 1'b1);
        tick();
        drive(a, b, c, u, 1'b0);
        repeat (LATENCY - 1) tick();
    endtask

    initial begin
        drive('0, '0, '0, '0, 1'b0);
        out_if.ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid_o", out_if.valid, 1'b0);
        check("reset_ready_o", in_if.ready, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_release", in_if.ready, 1'b1);

        // Default point alignment and exact latency
        drive(32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 16'hBEEF, 1'b1);
        tick();
        in_if.valid = 1'b0;
        repeat (LATENCY - 2) tick();
        check("latency_early", out_if.valid, 1'b0);
        tick();
        check("latency_valid", out_if.valid, 1'b1);
        check("dir_default", out_if.data, 32'h0002_8000);
        check("dir_user", user_def, 16'hBEEF);
        tick();

        send_one(32'hFFFF_0000, 32'h0002_0000, 32'h0, 16'h0001);
        check("dir_saturate", out_if.data, 32'hFFFF_FFFF);
        tick();
        send_one(32'h0000_0001, 32'h0000_8000, 32'h0, 16'h0002);
        check("dir_trunc", out_if.data, 32'h0);
        check("dir_round", out_rnd, 32'h1);
        tick();
        send_one(32'hFFFF_0000, 32'h0002_0000, 32'h0000_8000, 16'h0003);
        check("dir_signed", out_sgn, 32'hFFFE_8000);
        tick();

        // Random stream with bubbles, full throughput downstream
        for (int i = 0; i < 60; i++) begin
            drive(rnd_val(), rnd_val(), rnd_val(), U'($urandom), ($urandom_range(0, 4) != 0));
            tick();
        end

        // Backpressure: continuous input, consumer stalls for 10 cycles
        for (int i = 0; i < 30; i++) begin
            out_if.ready = !(i >= 5 && i < 15);
            drive(rnd_val(), rnd_val(), rnd_val(), U'($urandom), 1'b1);
            tick();
            if (i == 14) check("stall_ready_low", in_if.ready, 1'b0);
        end
        out_if.ready = 1'b1;
        in_if.valid  = 1'b0;
        repeat (LATENCY + 2) tick();
        check("drain_empty", q.size(), 0);
        check("drain_idle", out_if.valid, 1'b0);

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            drive(rnd_val(), rnd_val(), rnd_val(), U'($urandom), 1'b1);
            tick();
        end
        #3 rst = 1'b1;
        #1;
        check("midreset_valid_o", out_if.valid, 1'b0);
        check("midreset_ready_o", in_if.ready, 1'b0);
        q.delete();
        in_if.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midreset_release_ready", in_if.ready, 1'b1);
        send_one(32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 16'h1234);
        check("post_reset_out", out_if.data, 32'h0002_8000);
        check("post_reset_user", user_def, 16'h1234);
        repeat (LATENCY + 2) tick();
        check("post_reset_empty", q.size(), 0);
        check("post_reset_idle", out_if.valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
